// File: rtl/ht_pkg.sv
// ht_pkg: shared types and defaults for the ht_sched frame scheduler.
//   - ht_state_e    : controller states (load, run, wait, drain)
//   - HT_DEF_*      : default element width, frame length and wait timeout
//   - HT_FRAME_CNT_W: width of the completed-frame counter
//   - HT_WAIT_CNT_W : width of the optional WAIT-cycle counter
package ht_pkg;

    localparam int unsigned HT_DEF_WIDTH   = 4;
    localparam int unsigned HT_DEF_INDEX   = 8;
    localparam int unsigned HT_DEF_TIMEOUT = 64;
    localparam int unsigned HT_FRAME_CNT_W = 16;
    localparam int unsigned HT_WAIT_CNT_W  = 16;

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StWait,
        StDrain
    } ht_state_e;

endpackage

// File: rtl/ht_sched_buf.sv
// ht_sched_buf: INDEX x WIDTH register array used for both the input frame and the
// result frame of ht_sched.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every element)
//   wr_en      : write wr_data into element wr_idx
//   wr_idx     : element index for the single-element write
//   wr_data    : single-element write data
//   ld_en      : load all elements at once from ld_data (takes priority over wr_en)
//   ld_data    : flat parallel load data, element 0 in the low WIDTH bits
//   rd_data    : flat parallel read of the whole array, element 0 in the low bits
module ht_sched_buf
    import ht_pkg::*;
#(
    parameter int unsigned WIDTH       = HT_DEF_WIDTH,
    parameter int unsigned INDEX       = HT_DEF_INDEX,
    parameter int unsigned INDEX_WIDTH = $clog2(INDEX)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   ld_en,
    input  logic [INDEX*WIDTH-1:0] ld_data,
    output logic [INDEX*WIDTH-1:0] rd_data
);

    logic [INDEX-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (ld_en) begin
            mem_q <= ld_data;
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/ht_sched.sv
// ht_sched: collects INDEX serial elements into a frame, kicks an external transform
// datapath with a one-cycle ht_start, waits for ht_over, captures the result frame and
// streams it back out serially with out_last on the final element.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid, in_data, in_ready      : serial element input handshake
//   out_valid, out_data, out_last,
//   out_ready                        : serial result output handshake
//   ht_start, ht_indata              : datapath kick pulse and parallel input frame
//   ht_outdata, ht_over              : datapath parallel result and completion flag
//   busy                             : a frame is partially loaded or in flight
//   err                              : one-cycle pulse when the datapath times out
//   frame_cnt                        : number of fully drained frames (wraps)
// Build option: define HT_TIMEOUT_EN to abandon a frame after TIMEOUT WAIT cycles
// without ht_over; otherwise WAIT holds indefinitely and err is constant 0.
module ht_sched
    import ht_pkg::*;
#(
    parameter int unsigned WIDTH       = HT_DEF_WIDTH,
    parameter int unsigned INDEX       = HT_DEF_INDEX,
    parameter int unsigned INDEX_WIDTH = $clog2(INDEX),
    parameter int unsigned TIMEOUT     = HT_DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      ht_start,
    output logic [INDEX*WIDTH-1:0]    ht_indata,
    input  logic [INDEX*WIDTH-1:0]    ht_outdata,
    input  logic                      ht_over,
    output logic                      busy,
    output logic                      err,
    output logic [HT_FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(INDEX - 1);

    ht_state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0]    wr_idx_q, wr_idx_d;
    logic [INDEX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
    logic [HT_FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                      ht_start_q, ht_start_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;

    logic                      in_fire;
    logic                      out_fire;
    logic                      in_wr;
    logic                      res_ld;
    logic                      timeout_hit;
    logic [INDEX*WIDTH-1:0]    res_flat;
    logic [INDEX-1:0][WIDTH-1:0] res_arr;

    // Gated by rst_n so the input side reads as not-ready while reset is held.
    assign in_ready = rst_n && (state_q == StLoad);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // ------------------------------------------------------------------------
    // Optional WAIT timeout
    // ------------------------------------------------------------------------
`ifdef HT_TIMEOUT_EN
    localparam logic [HT_WAIT_CNT_W-1:0] WAIT_LIMIT = HT_WAIT_CNT_W'(TIMEOUT - 1);

    logic [HT_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                     err_q, err_d;

    // Counter sits at zero outside WAIT, so it always starts from zero on entry.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == StWait) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == StWait) && (wait_cnt_q == WAIT_LIMIT);
    // ht_over in the limit cycle wins over the timeout.
    assign err_d       = timeout_hit && !ht_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        frame_cnt_d = frame_cnt_q;
        in_wr       = 1'b0;
        res_ld      = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (in_fire) begin
                    in_wr = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = StRun;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            StRun: begin
                state_d = StWait;
            end
            StWait: begin
                if (ht_over) begin
                    res_ld  = 1'b1;
                    state_d = StDrain;
                end else if (timeout_hit) begin
                    state_d = StLoad;
                end
            end
            StDrain: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d    = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = StLoad;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        // Registered outputs are computed from next state so they line up with it.
        ht_start_d  = (state_d == StRun);
        out_valid_d = (state_d == StDrain);
        out_last_d  = (state_d == StDrain) && (rd_idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            frame_cnt_q <= '0;
            ht_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            frame_cnt_q <= frame_cnt_d;
            ht_start_q  <= ht_start_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame buffers
    // ------------------------------------------------------------------------
    // Only written in LOAD, so ht_indata is stable through RUN and WAIT.
    ht_sched_buf #(
        .WIDTH       (WIDTH),
        .INDEX       (INDEX),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_in_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_wr),
        .wr_idx  (wr_idx_q),
        .wr_data (in_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .rd_data (ht_indata)
    );

    ht_sched_buf #(
        .WIDTH       (WIDTH),
        .INDEX       (INDEX),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_res_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (res_ld),
        .ld_data (ht_outdata),
        .rd_data (res_flat)
    );

    assign res_arr = res_flat;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_data  = out_valid_q ? res_arr[rd_idx_q] : '0;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign ht_start  = ht_start_q;
    assign busy      = (state_q != StLoad) || (wr_idx_q != '0);
    assign frame_cnt = frame_cnt_q;

endmodule
